// File: rtl/font_loader_pkg.sv
// Shared definitions for the font loader: host command codes, RAM geometry
// and the controller state encoding.
package font_loader_pkg;

   localparam int FONT_ADDR_W = 11;
   localparam int FONT_ROWS   = 8;

   localparam logic [7:0] CMD_LOAD = 8'h01;
   localparam logic [7:0] CMD_READ = 8'h02;
   localparam logic [7:0] CMD_FILL = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_IDX,
      ST_LOAD,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_RD_SEND,
      ST_GET_FILL,
      ST_FILL
   } state_t;

   typedef enum logic {
      MODE_WRITE,
      MODE_READ
   } mode_t;

endpackage

// File: rtl/font_loader.sv
// Host-driven loader for the character RAM: loads or reads back one glyph at a
// time over a byte stream, or fills the whole RAM with a constant.
module font_loader
   import font_loader_pkg::*;
#(
   parameter int ADDR_W = FONT_ADDR_W,
   parameter int ROWS   = FONT_ROWS
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic              ram_ce,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout,
   output logic              busy,
   output logic              err
);

   localparam int ROW_W   = $clog2(ROWS);
   localparam int GLYPH_W = ADDR_W - ROW_W;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   state_t              state;
   state_t              state_next;
   mode_t               mode;
   logic [1:0]          rst_sync;
   logic [GLYPH_W-1:0]  glyph;
   logic [ROW_W-1:0]    row;
   logic [ADDR_W-1:0]   counter;
   logic [7:0]          fill_val;
   logic [ADDR_W-1:0]   glyph_addr;
   logic                accept;

   // Reset asserts asynchronously but is released only after two clock edges,
   // so the controller never wakes up on a metastable deassertion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign glyph_addr = {glyph, row};
   assign in_ready   = rst_sync[1] &&
                       (state inside {ST_IDLE, ST_GET_IDX, ST_LOAD, ST_GET_FILL});
   assign accept     = in_valid && in_ready;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (rst_sync[1]) begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (in_data)
                  CMD_LOAD: state_next = ST_GET_IDX;
                  CMD_READ: state_next = ST_GET_IDX;
                  CMD_FILL: state_next = ST_GET_FILL;
                  default:  state_next = ST_IDLE;
               endcase
            end
         end
         ST_GET_IDX: begin
            if (accept) begin
               state_next = (mode == MODE_WRITE) ? ST_LOAD : ST_RD_ISSUE;
            end
         end
         ST_LOAD: begin
            if (accept && (row == ROW_LAST)) begin
               state_next = ST_IDLE;
            end
         end
         ST_RD_ISSUE: state_next = ST_RD_WAIT;
         ST_RD_WAIT:  state_next = ST_RD_SEND;
         ST_RD_SEND: begin
            if (out_ready) begin
               state_next = (row == ROW_LAST) ? ST_IDLE : ST_RD_ISSUE;
            end
         end
         ST_GET_FILL: begin
            if (accept) begin
               state_next = ST_FILL;
            end
         end
         ST_FILL: begin
            if (counter == '1) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // RAM strobes are combinational so a load byte is written in the very
   // cycle it is accepted; they collapse at once when reset asserts.
   always_comb begin
      out_valid = 1'b0;
      ram_ce    = 1'b0;
      ram_wre   = 1'b0;
      ram_ad    = '0;
      ram_din   = '0;
      case (state)
         ST_LOAD: begin
            if (accept) begin
               ram_ce  = 1'b1;
               ram_wre = 1'b1;
               ram_ad  = glyph_addr;
               ram_din = in_data;
            end
         end
         ST_RD_ISSUE: begin
            ram_ce = 1'b1;
            ram_ad = glyph_addr;
         end
         ST_RD_SEND: out_valid = 1'b1;
         ST_FILL: begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = counter;
            ram_din = fill_val;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode     <= MODE_WRITE;
         glyph    <= '0;
         row      <= '0;
         counter  <= '0;
         fill_val <= '0;
         out_data <= '0;
         err      <= 1'b0;
      end else if (rst_sync[1]) begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (in_data)
                     CMD_LOAD: mode <= MODE_WRITE;
                     CMD_READ: mode <= MODE_READ;
                     CMD_FILL: ;
                     default:  err  <= 1'b1;
                  endcase
               end
            end
            ST_GET_IDX: begin
               if (accept) begin
                  glyph <= GLYPH_W'(in_data);
                  row   <= '0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  row <= row + ROW_W'(1);
               end
            end
            ST_RD_WAIT: out_data <= ram_dout;
            ST_RD_SEND: begin
               if (out_ready) begin
                  row <= row + ROW_W'(1);
               end
            end
            ST_GET_FILL: begin
               if (accept) begin
                  fill_val <= in_data;
                  counter  <= '0;
               end
            end
            ST_FILL: counter <= counter + ADDR_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_font_loader.sv
// Scoreboard bench for font_loader: stimulus queues expected RAM accesses,
// readback bytes and error pulses; a negedge monitor pops and compares them.
module tb_font_loader;
   import font_loader_pkg::*;

   localparam int ADDR_W = 11;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_ready = 1'b0;
   logic              ram_ce;
   logic              ram_wre;
   logic [ADDR_W-1:0] ram_ad;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout = 8'h00;
   logic              busy;
   logic              err;

   typedef enum logic [1:0] {EV_WR, EV_RD, EV_OUT, EV_ERR} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [10:0] addr;
      logic [7:0]  data;
   } ev_t;

   ev_t        exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] mem [0:2047];

   localparam logic [63:0] GLYPH_A   = 64'h18244242_7E424200;
   localparam logic [63:0] GLYPH_FF  = 64'hA1B2C3D4_E5F60718;
   localparam logic [63:0] GLYPH_10  = 64'h0F1E2D3C_4B5A6978;

   font_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .ram_ce    (ram_ce),
      .ram_wre   (ram_wre),
      .ram_ad    (ram_ad),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Character RAM model: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_wre) mem[ram_ad] <= ram_din;
         else         ram_dout    <= mem[ram_ad];
      end
   end

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic take_event(input ev_t got, input bit do_pop);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL unexpected_event: got %h expected none at %0t", got, $time);
      end else begin
         check_output("event", 32'(got), 32'(exp_q[0]));
         if (do_pop) void'(exp_q.pop_front());
      end
   endtask

   always @(negedge clk) begin
      ev_t ev;
      if (rst_n) begin
         check_output("ready_valid_excl", 32'(out_valid & in_ready), 32'd0);
         if (ram_ce) begin
            if (ram_wre) ev.kind = EV_WR;
            else         ev.kind = EV_RD;
            ev.addr = ram_ad;
            ev.data = ram_wre ? ram_din : 8'h00;
            take_event(ev, 1'b1);
         end
         if (out_valid) begin
            ev.kind = EV_OUT;
            ev.addr = 11'h000;
            ev.data = out_data;
            take_event(ev, out_ready);
         end
         if (err) begin
            ev.kind = EV_ERR;
            ev.addr = 11'h000;
            ev.data = 8'h00;
            take_event(ev, 1'b1);
         end
      end
   end

   task automatic push_ev(input ev_kind_t k, input logic [10:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Called aligned #1 after a rising edge; returns aligned the same way.
   task automatic apply_stimulus(input logic [7:0] b);
      bit done = 1'b0;
      int cyc = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!done && cyc < 50) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL handshake_timeout: got in_ready=0 expected 1 for byte %h", b);
      end
   endtask

   task automatic load_glyph(input logic [7:0] g, input logic [63:0] d);
      for (int r = 0; r < 8; r++) push_ev(EV_WR, {g, 3'(r)}, d[63-8*r -: 8]);
      apply_stimulus(CMD_LOAD);
      apply_stimulus(g);
      for (int r = 0; r < 8; r++) apply_stimulus(d[63-8*r -: 8]);
      @(negedge clk);
      check_output("load_busy_after", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic read_glyph(input logic [7:0] g, input logic [63:0] d, input int stall_row);
      int i = 0;
      int stalls = 0;
      int cyc = 0;
      for (int r = 0; r < 8; r++) begin
         push_ev(EV_RD, {g, 3'(r)}, 8'h00);
         push_ev(EV_OUT, 11'h000, d[63-8*r -: 8]);
      end
      apply_stimulus(CMD_READ);
      apply_stimulus(g);
      out_ready = 1'b0;
      while (i < 8 && cyc < 200) begin
         if (out_valid && i == stall_row && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
         end else begin
            out_ready = out_valid;
            if (out_valid) i++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      out_ready = 1'b0;
      check_output("read_bytes", 32'(i), 32'd8);
      @(negedge clk);
      check_output("read_busy_after", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_and_release();
      @(negedge clk);
      check_output("rst_busy",      32'(busy),      32'd0);
      check_output("rst_err",       32'(err),       32'd0);
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_ram_ce",    32'(ram_ce),    32'd0);
      check_output("rst_ram_wre",   32'(ram_wre),   32'd0);
      check_output("rst_ram_ad",    32'(ram_ad),    32'd0);
      check_output("rst_ram_din",   32'(ram_din),   32'd0);
      check_output("rst_out_data",  32'(out_data),  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_output("sync_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_output("sync_ready_high", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      bit hit;
      for (int a = 0; a < 2048; a++) mem[a] = 8'h00;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      reset_and_release();

      // Glyph 'A' load then readback with a three-cycle stall on row 2
      load_glyph(8'h41, GLYPH_A);
      read_glyph(8'h41, GLYPH_A, 2);

      // Full-RAM fill with zero
      for (int a = 0; a < 2048; a++) push_ev(EV_WR, 11'(a), 8'h00);
      apply_stimulus(CMD_FILL);
      apply_stimulus(8'h00);
      cyc = 0;
      do begin
         @(negedge clk);
         if (busy) begin
            check_output("fill_in_ready", 32'(in_ready), 32'd0);
            cyc++;
         end
      end while (busy && cyc < 3000);
      check_output("fill_cycles", 32'(cyc), 32'd2048);
      check_output("fill_busy_after", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Unknown command
      push_ev(EV_ERR, 11'h000, 8'h00);
      apply_stimulus(8'h7F);
      repeat (3) begin
         @(negedge clk);
         check_output("badcmd_busy", 32'(busy), 32'd0);
      end
      @(posedge clk);
      #1;

      // Last glyph wraps to the top address, then a clean readback
      load_glyph(8'hFF, GLYPH_FF);
      read_glyph(8'hFF, GLYPH_FF, 8);

      // Reset asserted while the fill presents address 0x100
      for (int a = 0; a < 256; a++) push_ev(EV_WR, 11'(a), 8'hAA);
      apply_stimulus(CMD_FILL);
      apply_stimulus(8'hAA);
      hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < 400) begin
         if (ram_ce && ram_ad == 11'h100) hit = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      check_output("fill_reached_100", 32'(hit), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("abort_ram_ce",  32'(ram_ce),  32'd0);
      check_output("abort_ram_wre", 32'(ram_wre), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check_output("abort_quiet", 32'({ram_ce, ram_wre}), 32'd0);
      end
      check_output("abort_kept_row", 32'(mem[11'h0FF]), 32'hAA);
      @(posedge clk);
      #1;
      reset_and_release();
      load_glyph(8'h10, GLYPH_10);

      repeat (4) @(posedge clk);
      check_output("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/font_loader.md
FONT_LOADER -- requirements
Module: font_loader

Interface
REQ-001 Parameter ADDR_W, default 11: character-RAM address width (256 glyphs x 8 rows).
REQ-002 Parameter ROWS, default 8: rows per glyph; index-to-address is {glyph[7:0], row[2:0]}.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host command/data byte valid.
REQ-006 in_data  input  8  host byte.
REQ-007 in_ready  output  1  byte accepted when in_valid & in_ready.
REQ-008 out_valid  output  1  readback byte valid.
REQ-009 out_data  output  8  readback byte.
REQ-010 out_ready  input  1  host accepts readback byte.
REQ-011 ram_ce  output  1  character-RAM port enable.
REQ-012 ram_wre  output  1  character-RAM write enable.
REQ-013 ram_ad  output  ADDR_W  character-RAM address.
REQ-014 ram_din  output  8  character-RAM write data.
REQ-015 ram_dout  input  8  character-RAM read data, valid one clk after ram_ce with ram_wre=0.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err  output  1  one-cycle pulse on an unknown command byte.

Function
REQ-018 States: IDLE, GET_IDX, LOAD, RD_ISSUE, RD_WAIT, RD_SEND, GET_FILL, FILL.
REQ-019 in_ready SHALL be high only in IDLE, GET_IDX, LOAD and GET_FILL.
REQ-020 IDLE, accepted byte: 0x01 goes to GET_IDX with mode=write; 0x02 goes to GET_IDX with mode=read; 0x03 goes to GET_FILL; any other value pulses err and stays in IDLE.
REQ-021 GET_IDX: accepted byte latches glyph and clears row; mode=write goes to LOAD, mode=read goes to RD_ISSUE.
REQ-022 LOAD: each accepted byte drives ram_ce=1, ram_wre=1, ram_ad={glyph,row}, ram_din=byte in that same cycle, then row increments; the 8th write returns to IDLE.
REQ-023 RD_ISSUE: drive ram_ce=1, ram_wre=0, ram_ad={glyph,row} for one cycle, then go to RD_WAIT.
REQ-024 RD_WAIT: capture ram_dout into out_data, then go to RD_SEND.
REQ-025 RD_SEND: hold out_valid=1 and out_data stable until out_ready. On transfer, row increments; row 7 transferred goes to IDLE, otherwise to RD_ISSUE.
REQ-026 GET_FILL: accepted byte latches the fill value and clears a 11-bit counter; go to FILL.
REQ-027 FILL: write the fill value to ram_ad=counter every cycle (ram_ce=ram_wre=1); after address 2047, go to IDLE. Fill takes exactly 2048 cycles.
REQ-028 ram_ce and ram_wre SHALL be 0 in every cycle not listed in REQ-022, REQ-023 and REQ-027.
REQ-029 Row and counter wrap modulo 8 and 2^ADDR_W; glyph 0xFF row 7 maps to address 2047.
REQ-030 out_valid SHALL never coincide with in_ready; input and readback are mutually exclusive.
REQ-031 in_valid arriving while in_ready=0 is not consumed; the host holds it.

Reset
REQ-032 While rst_n=0: state=IDLE; busy, err, out_valid, ram_ce and ram_wre = 0; ram_ad, ram_din, out_data, glyph, row and counter = 0.
REQ-033 Reset asserted mid-LOAD, mid-FILL or mid-readback aborts immediately; no RAM access is issued after reset asserts, and rows already written remain written.
REQ-034 Reset release is synchronised internally, so the first state change occurs at or after the 2nd clk edge following deassertion.

Structure
REQ-035 A shared font package holds: command codes CMD_LOAD=0x01, CMD_READ=0x02, CMD_FILL=0x03; ROWS; ADDR_W; and the state enum.
REQ-036 A single flat module; no sub-module. The RAM stays external and connects to the font RAM's second port.

Verification
REQ-037 Load: stream 01,41,18,24,42,42,7E,42,42,00 -> 8 writes at 0x208-0x20F with data 18,24,42,42,7E,42,42,00; busy drops the cycle after the last write.
REQ-038 Readback: 02,41 with out_ready stalled 3 cycles on row 2 -> out_data stays 42 while stalled; all 8 bytes return in order, then IDLE.
REQ-039 Fill: 03,00 -> 2048 consecutive writes at 0x000-0x7FF, in_ready low throughout, busy low afterward.
REQ-040 Bad command: 0x7F -> err high for exactly 1 cycle, no RAM access, state stays IDLE.
REQ-041 Reset at fill address 0x100 -> no RAM access after reset asserts; after release, a new 01 command is accepted normally.
REQ-042 Wrap: load glyph 0xFF -> last write at 0x7FF; the next command starts cleanly.
